// File: rtl/l1_refill_ctrl.sv
// L1 refill sequencer: CPU port lookup, read-miss line refill with critical-word capture,
// write-through (no-write-allocate) writes, and saturating hit/miss counters.
module l1_refill_ctrl #(
    parameter int unsigned WORDS_PER_LINE = 8,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             cpu_ready,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_busy,
    output logic             cache_rd,
    output logic             cache_wr,
    output logic             cache_fill,
    output logic [31:0]      cache_addr,
    output logic [31:0]      cache_wdata,
    input  logic             cache_hit,
    input  logic [31:0]      cache_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
    localparam int unsigned LB    = OFF_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_CHECK, S_CWRITE, S_WMEM, S_RREQ, S_RDATA, S_DONE
    } state_t;

    state_t             state, state_d;
    logic               we_q, we_d;
    logic [31:2]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [OFF_W-1:0]   beat, beat_d;

    logic               cpu_ready_d, cpu_busy_d;
    logic [31:0]        cpu_rdata_d;
    logic               cache_rd_d, cache_wr_d, cache_fill_d;
    logic [31:0]        cache_addr_d, cache_wdata_d;
    logic               mem_req_d, mem_we_d;
    logic [31:0]        mem_addr_d, mem_wdata_d;
    logic [CNT_W-1:0]   hit_cnt_d, miss_cnt_d;

    logic [31:0]        word_addr, line_addr;
    logic [OFF_W-1:0]   word_off;
    logic               unused_addr_bits;

    assign word_addr        = {addr_q, 2'b00};
    assign line_addr        = {addr_q[31:LB], LB'(0)};
    assign word_off         = addr_q[LB-1:2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d       = state;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        beat_d        = beat;
        cpu_ready_d   = 1'b0;
        cpu_rdata_d   = cpu_rdata;
        cache_rd_d    = 1'b0;
        cache_wr_d    = 1'b0;
        cache_fill_d  = 1'b0;
        cache_addr_d  = cache_addr;
        cache_wdata_d = cache_wdata;
        mem_req_d     = 1'b0;
        mem_we_d      = mem_we;
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        hit_cnt_d     = hit_cnt;
        miss_cnt_d    = miss_cnt;

        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d         = cpu_we;
                    addr_d       = cpu_addr[31:2];
                    wdata_d      = cpu_wdata;
                    cache_rd_d   = 1'b1;
                    cache_addr_d = {cpu_addr[31:2], 2'b00};
                    state_d      = S_LOOKUP;
                end
            end
            S_LOOKUP: state_d = S_CHECK;
            S_CHECK: begin
                if (cache_hit) begin
                    if (hit_cnt != {CNT_W{1'b1}}) hit_cnt_d = hit_cnt + CNT_W'(1);
                end else begin
                    if (miss_cnt != {CNT_W{1'b1}}) miss_cnt_d = miss_cnt + CNT_W'(1);
                end
                if (we_q && cache_hit) begin
                    cache_wr_d    = 1'b1;
                    cache_addr_d  = word_addr;
                    cache_wdata_d = wdata_q;
                    state_d       = S_CWRITE;
                end else if (we_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = word_addr;
                    mem_wdata_d = wdata_q;
                    state_d     = S_WMEM;
                end else if (cache_hit) begin
                    cpu_rdata_d = cache_rdata;
                    cpu_ready_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr;
                    state_d    = S_RREQ;
                end
            end
            S_CWRITE: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = word_addr;
                mem_wdata_d = wdata_q;
                state_d     = S_WMEM;
            end
            S_WMEM: begin
                if (mem_gnt) begin
                    cpu_ready_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_RREQ: begin
                if (mem_gnt) begin
                    beat_d  = '0;
                    state_d = S_RDATA;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            S_RDATA: begin
                if (mem_rvalid) begin
                    cache_fill_d  = 1'b1;
                    cache_addr_d  = {addr_q[31:LB], beat, 2'b00};
                    cache_wdata_d = mem_rdata;
                    beat_d        = beat + OFF_W'(1);
                    if (beat == word_off) cpu_rdata_d = mem_rdata;
                    // Last beat's fill strobe lands in DONE, alongside cpu_ready
                    if (beat == OFF_W'(WORDS_PER_LINE - 1)) begin
                        cpu_ready_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
        endcase

        cpu_busy_d = (state_d != S_IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            beat        <= '0;
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            cpu_busy    <= 1'b0;
            cache_rd    <= 1'b0;
            cache_wr    <= 1'b0;
            cache_fill  <= 1'b0;
            cache_addr  <= '0;
            cache_wdata <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
        end else begin
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            beat        <= beat_d;
            cpu_ready   <= cpu_ready_d;
            cpu_rdata   <= cpu_rdata_d;
            cpu_busy    <= cpu_busy_d;
            cache_rd    <= cache_rd_d;
            cache_wr    <= cache_wr_d;
            cache_fill  <= cache_fill_d;
            cache_addr  <= cache_addr_d;
            cache_wdata <= cache_wdata_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            hit_cnt     <= hit_cnt_d;
            miss_cnt    <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
// Scoreboard bench for l1_refill_ctrl: bench-side cache array and memory responders,
// a transaction-level reference model, and monitors that pop expected events.
module tb_l1_refill_ctrl;

    localparam int unsigned WPL   = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]      cpu_addr = '0, cpu_wdata = '0;
    logic             cpu_ready, cpu_busy;
    logic [31:0]      cpu_rdata;
    logic             cache_rd, cache_wr, cache_fill;
    logic [31:0]      cache_addr, cache_wdata;
    logic             cache_hit = 1'b0;
    logic [31:0]      cache_rdata = '0;
    logic             mem_req, mem_we;
    logic [31:0]      mem_addr, mem_wdata;
    logic             mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0]      mem_rdata = '0;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    l1_refill_ctrl #(.WORDS_PER_LINE(WPL), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .cache_rd(cache_rd), .cache_wr(cache_wr), .cache_fill(cache_fill),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [31:0] rdata; int hit; int miss; } resp_t;
    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } memreq_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;

    resp_t   exp_resp[$];
    memreq_t exp_mem[$];
    wr_t     exp_cwr[$];
    wr_t     exp_fill[$];

    int checks = 0, failures = 0;
    int issued = 0, rd_count = 0, fill_count = 0;
    int gnt_delay = -1, cur_beat = -1;
    bit burst_active = 0, burst_aborted = 0;

    // Reference model state
    logic [31:0] ref_mem [logic [31:0]];
    bit          ref_lines [logic [31:0]];
    int          ref_hit = 0, ref_miss = 0;

    // Bench-side physical memory and cache array
    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] cache_mem [logic [31:0]];
    bit          cache_valid [logic [31:0]];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_rd(logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [31:0] phys_rd(logic [31:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    task automatic finish_bench();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    // Issue one CPU access: predict its effects, then drive it until completion
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] line, waddr, rdata;
        bit          hit, got;
        int          n;
        line  = addr & ~32'(WPL * 4 - 1);
        waddr = addr & ~32'h3;
        hit   = ref_lines.exists(line);
        if (hit) ref_hit  = (ref_hit  < CMAX) ? ref_hit + 1  : CMAX;
        else     ref_miss = (ref_miss < CMAX) ? ref_miss + 1 : CMAX;
        rdata = '0;
        if (we) begin
            if (hit) exp_cwr.push_back('{waddr, wdata});
            exp_mem.push_back('{1'b1, waddr, wdata});
            ref_mem[waddr] = wdata;
        end else begin
            if (!hit) begin
                exp_mem.push_back('{1'b0, line, 32'h0});
                for (int i = 0; i < WPL; i++)
                    exp_fill.push_back('{line + 32'(4 * i), ref_rd(line + 32'(4 * i))});
                ref_lines[line] = 1'b1;
            end
            rdata = ref_rd(waddr);
        end
        exp_resp.push_back('{we, rdata, ref_hit, ref_miss});
        issued++;

        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        n = 0; got = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_after_accept", 32'(cpu_busy), 32'd1);
            if (cpu_ready) got = 1;
        end
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
        if (!got) begin
            check("cpu_ready_timeout", 32'd0, 32'd1);
            finish_bench();
        end
        if (!we && hit) check("read_hit_latency", 32'(n), 32'd3);
    endtask

    // Response monitor
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_cpu_ready", 32'd1, 32'd0);
                end else begin
                    r = exp_resp.pop_front();
                    if (!r.we) check("cpu_rdata", cpu_rdata, r.rdata);
                    check("hit_cnt", 32'(hit_cnt), 32'(r.hit));
                    check("miss_cnt", 32'(miss_cnt), 32'(r.miss));
                end
            end
        end
    end

    // Cache array responder and cache-side monitor
    initial begin
        bit          pend;
        logic [31:0] la;
        wr_t         e;
        forever begin
            @(negedge clk);
            pend = cache_rd;
            la   = cache_addr;
            if (cache_rd) rd_count++;
            if (cache_wr) begin
                if (exp_cwr.size() == 0) check("unexpected_cache_wr", cache_addr, 32'hFFFF_FFFF);
                else begin
                    e = exp_cwr.pop_front();
                    check("cache_wr_addr", cache_addr, e.addr);
                    check("cache_wr_data", cache_wdata, e.data);
                end
                cache_mem[cache_addr] = cache_wdata;
            end
            if (cache_fill) begin
                fill_count++;
                if (exp_fill.size() == 0) check("unexpected_cache_fill", cache_addr, 32'hFFFF_FFFF);
                else begin
                    e = exp_fill.pop_front();
                    check("fill_addr", cache_addr, e.addr);
                    check("fill_data", cache_wdata, e.data);
                end
                cache_mem[cache_addr] = cache_wdata;
                // A line becomes valid only once its final word has been written
                if (cache_addr[4:2] == 3'(WPL - 1))
                    cache_valid[cache_addr & ~32'(WPL * 4 - 1)] = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pend) begin
                cache_hit   = cache_valid.exists(la & ~32'(WPL * 4 - 1));
                cache_rdata = cache_mem.exists(la) ? cache_mem[la] : $urandom;
            end else begin
                cache_hit   = 1'($urandom);
                cache_rdata = $urandom;
            end
        end
    end

    // Memory responder: random grant delay, bursts with random gaps
    initial begin
        int          d;
        logic        g_we;
        logic [31:0] g_addr, g_wd;
        memreq_t     e;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                d = (gnt_delay >= 0) ? gnt_delay : int'($urandom_range(0, 3));
                repeat (d) @(negedge clk);
                check("mem_req_held", 32'(mem_req), 32'd1);
                mem_gnt = 1'b1;
                g_we = mem_we; g_addr = mem_addr; g_wd = mem_wdata;
                if (exp_mem.size() == 0) check("unexpected_mem_req", g_addr, 32'hFFFF_FFFF);
                else begin
                    e = exp_mem.pop_front();
                    check("mem_we", 32'(g_we), 32'(e.we));
                    check("mem_addr", g_addr, e.addr);
                    if (e.we) check("mem_wdata", g_wd, e.wdata);
                end
                @(negedge clk);
                mem_gnt = 1'b0;
                if (g_we) phys_mem[g_addr] = g_wd;
                else begin
                    burst_active = 1;
                    for (int b = 0; b < WPL; b++) begin
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        mem_rvalid = 1'b1;
                        cur_beat   = b;
                        mem_rdata  = phys_rd(g_addr + 32'(4 * b));
                        @(negedge clk);
                        mem_rvalid = 1'b0;
                        mem_rdata  = $urandom;
                    end
                    cur_beat = -1;
                    if (!burst_aborted) check("miss_done_after_last_beat", 32'(cpu_ready), 32'd1);
                    burst_active = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        check("global_timeout", 32'd0, 32'd1);
        finish_bench();
    end

    // Main stimulus
    initial begin
        int n, fills_at_reset;
        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_cpu_busy", 32'(cpu_busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_counters", 32'({hit_cnt, miss_cnt}), 32'd0);
        reset = 1'b0;

        // Fill a line via miss, then hit within it
        access(1'b0, 32'h0000_1000, 32'h0);
        access(1'b0, 32'h0000_1008, 32'h0);
        check("hit_cnt_after_first_hit", 32'(hit_cnt), 32'd1);

        // Cold read, critical word in the middle, slow grant
        for (int i = 0; i < WPL; i++) begin
            phys_mem[32'h2000 + 32'(4 * i)] = 32'hA0 + 32'(i);
            ref_mem[32'h2000 + 32'(4 * i)]  = 32'hA0 + 32'(i);
        end
        gnt_delay = 4;
        access(1'b0, 32'h0000_2014, 32'h0);
        gnt_delay = -1;
        check("critical_word", cpu_rdata, 32'hA5);
        check("miss_cnt_after_cold", 32'(miss_cnt), 32'd2);

        // Write miss, then write hit and read back
        access(1'b1, 32'h0000_3000, 32'h0000_DEAD);
        access(1'b1, 32'h0000_1004, 32'h0000_BEEF);
        access(1'b0, 32'h0000_1004, 32'h0);
        check("write_hit_readback", cpu_rdata, 32'h0000_BEEF);

        // Random mix over a small set of lines; counters saturate at 4 bits
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            a = 32'h6000 + 32'($urandom_range(0, 5)) * 32'(WPL * 4) + 32'($urandom_range(0, 31));
            access(1'($urandom_range(0, 2) == 0), a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        check("hit_cnt_saturated", 32'(hit_cnt), 32'(CMAX));

        // Reset during beat 3 of a refill
        exp_mem.push_back('{1'b0, 32'h5000, 32'h0});
        for (int i = 0; i < 3; i++)
            exp_fill.push_back('{32'h5000 + 32'(4 * i), ref_rd(32'h5000 + 32'(4 * i))});
        issued++;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5014;
        n = 0;
        while (!(mem_rvalid && cur_beat == 3) && n < 300) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("reached_beat3", 32'(cur_beat), 32'd3);
        burst_aborted = 1;
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        fills_at_reset = fill_count;
        check("rst_mid_ready_busy", 32'({cpu_ready, cpu_busy}), 32'd0);
        check("rst_mid_cache_strobes", 32'({cache_rd, cache_wr, cache_fill}), 32'd0);
        check("rst_mid_cache_addr", cache_addr, 32'd0);
        check("rst_mid_cache_wdata", cache_wdata, 32'd0);
        check("rst_mid_mem_req_we", 32'({mem_req, mem_we}), 32'd0);
        check("rst_mid_mem_addr", mem_addr, 32'd0);
        check("rst_mid_mem_wdata", mem_wdata, 32'd0);
        check("rst_mid_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mid_counters", 32'({hit_cnt, miss_cnt}), 32'd0);
        ref_hit = 0; ref_miss = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(cpu_busy), 32'd0);
        n = 0;
        while (burst_active && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("burst_drained", 32'(burst_active), 32'd0);
        check("no_fill_after_reset", 32'(fill_count), 32'(fills_at_reset));
        burst_aborted = 0;

        // Recovery: the abandoned line misses again, then hits
        access(1'b0, 32'h0000_5014, 32'h0);
        access(1'b0, 32'h0000_5000, 32'h0);
        access(1'b1, 32'h0000_7008, 32'h1234_5678);
        check("counters_after_recovery", 32'({hit_cnt, miss_cnt}), 32'({4'd1, 4'd2}));

        repeat (5) @(negedge clk);
        check("lookups_equal_accepts", 32'(rd_count), 32'(issued));
        check("exp_resp_drained", 32'(exp_resp.size()), 32'd0);
        check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
        check("exp_fill_drained", 32'(exp_fill.size()), 32'd0);
        check("exp_cwr_drained", 32'(exp_cwr.size()), 32'd0);
        finish_bench();
    end

endmodule
